// File: rtl/display_arbiter.sv
// Two-requester arbiter for an 8-digit hex seven-segment bank.
// Ownership is held for a minimum of HOLD_CYCLES cycles. Once that time is up,
// the other requester may pre-empt unless lock is high. All outputs are
// registered.
`timescale 1ns/1ps

// One digit of leading-zero suppression. The digit goes dark when it and every
// digit above it are zero, unless force_show keeps it lit.
module display_arbiter_digit (
  input  logic [3:0] nibble,
  input  logic       zero_above,
  input  logic       force_show,
  output logic       blank
);
  assign blank = zero_above & (nibble == 4'h0) & ~force_show;
endmodule

module display_arbiter #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_a,
  input  logic [31:0] value_a,
  input  logic        req_b,
  input  logic [31:0] value_b,
  input  logic        lock,
  output logic        grant_a,
  output logic        grant_b,
  output logic [31:0] disp_value,
  output logic [7:0]  disp_blank
);
  localparam int NUM_DIGITS = 8;
  localparam int CNT_W      = 26;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic               last_owner, nxt_last;
  logic [31:0]        nxt_value;
  logic               enter_a, enter_b;
  logic [NUM_DIGITS-1:0]      nxt_blank;
  logic [NUM_DIGITS-1:0][3:0] nxt_digits;
  logic [NUM_DIGITS-1:0]      zero_chain;
  logic                       nxt_granted;

  // Next-state, counter and display value; entry actions shared via enter_a/enter_b
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_last  = last_owner;
    nxt_value = disp_value;
    enter_a   = 1'b0;
    enter_b   = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_cnt   = '0;
        nxt_value = '0;
        // On a tie, grant whoever did not own last.
        if (req_a && (!req_b || last_owner == OWNER_B)) enter_a = 1'b1;
        else if (req_b)                                 enter_b = 1'b1;
      end
      OWN_A: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
          if (req_a) nxt_value = value_a;
        end else if (req_b && !lock) begin
          enter_b = 1'b1;
        end else if (req_a) begin
          nxt_value = value_a;
        end else begin
          nxt_state = IDLE;
          nxt_value = '0;
        end
      end
      OWN_B: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
          if (req_b) nxt_value = value_b;
        end else if (req_a && !lock) begin
          enter_a = 1'b1;
        end else if (req_b) begin
          nxt_value = value_b;
        end else begin
          nxt_state = IDLE;
          nxt_value = '0;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_value = '0;
      end
    endcase
    if (enter_a) begin
      nxt_state = OWN_A;
      nxt_cnt   = HOLD_LOAD;
      nxt_last  = OWNER_A;
      nxt_value = value_a;
    end else if (enter_b) begin
      nxt_state = OWN_B;
      nxt_cnt   = HOLD_LOAD;
      nxt_last  = OWNER_B;
      nxt_value = value_b;
    end
  end

  // Blank flags are derived from the value about to be registered, so both
  // land on the same edge.
  assign nxt_digits  = nxt_value;
  assign nxt_granted = (nxt_state != IDLE);

  // zero_chain[i]: every digit strictly above digit i is zero.
  assign zero_chain[NUM_DIGITS-1] = 1'b1;
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS - 1; g++) begin : g_chain
      assign zero_chain[g] = zero_chain[g+1] & (nxt_digits[g+1] == 4'h0);
    end
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      // Digit 0 stays lit while granted so a zero value still shows "0".
      display_arbiter_digit u_digit (
        .nibble     (nxt_digits[g]),
        .zero_above (zero_chain[g]),
        .force_show ((g == 0) ? nxt_granted : 1'b0),
        .blank      (nxt_blank[g])
      );
    end
  endgenerate

  // State register and registered outputs; reset drops everything immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWNER_B;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      disp_value <= '0;
      disp_blank <= 8'hFF;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      last_owner <= nxt_last;
      grant_a    <= (nxt_state == OWN_A);
      grant_b    <= (nxt_state == OWN_B);
      disp_value <= nxt_value;
      disp_blank <= nxt_blank;
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with a short hold time.
`timescale 1ns/1ps

module tb_display_arbiter;
  logic        clock;
  logic        resetn;
  logic        req_a, req_b, lock;
  logic [31:0] value_a, value_b;
  logic        grant_a, grant_b;
  logic [31:0] disp_value;
  logic [7:0]  disp_blank;

  typedef struct packed {
    logic        ga;
    logic        gb;
    logic [31:0] val;
    logic [7:0]  blk;
  } exp_t;

  localparam exp_t IDLE_EXP = '{1'b0, 1'b0, 32'h0, 8'hFF};

  exp_t sb[$];
  exp_t obs;
  int   n_checks = 0;
  int   n_errs   = 0;

  assign obs = '{grant_a, grant_b, disp_value, disp_blank};

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_a      (req_a),
    .value_a    (value_a),
    .req_b      (req_b),
    .value_b    (value_b),
    .lock       (lock),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .disp_value (disp_value),
    .disp_blank (disp_blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Short reset pulse to start a scenario from a known state.
  task automatic do_reset();
    req_a = 0; req_b = 0; lock = 0; value_a = '0; value_b = '0;
    resetn = 0;
    @(posedge clock); #1;
    resetn = 1;
  endtask

  task automatic test_reset();
    exp_t e;
    req_a = 1; req_b = 1; lock = 0;
    value_a = 32'h0000_00C3; value_b = 32'h0000_0077;
    #2 resetn = 0;
    sb.push_back(IDLE_EXP);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL reset_async got %h exp %h", obs, e); end
    for (int k = 0; k < 2; k++) begin
      sb.push_back(IDLE_EXP);
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL reset_held c%0d got %h exp %h", k, obs, e); end
    end
    resetn = 1;
    sb.push_back('{1'b1, 1'b0, 32'h0000_00C3, 8'hFC});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL reset_first_grant got %h exp %h", obs, e); end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    req_a = 1; value_a = 32'h0000_0A05;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        value_a = 32'h0001_0000;
        sb.push_back('{1'b1, 1'b0, 32'h0001_0000, 8'hE0});
      end else begin
        sb.push_back('{1'b1, 1'b0, 32'h0000_0A05, 8'hF8});
      end
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL single c%0d got %h exp %h", k, obs, e); end
    end
    req_a = 0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(IDLE_EXP);
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL single_release c%0d got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    do_reset();
    req_a = 1; value_a = 32'h0000_0011;
    value_b = 32'h2222_2222;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) req_b = 1;
      if (k < 4 || k == 8) sb.push_back('{1'b1, 1'b0, 32'h0000_0011, 8'hFC});
      else                 sb.push_back('{1'b0, 1'b1, 32'h2222_2222, 8'h00});
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL preempt c%0d got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_lock();
    exp_t e;
    do_reset();
    req_a = 1; req_b = 1; lock = 1;
    value_a = 32'h0000_0005; value_b = 32'h0000_F000;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{1'b1, 1'b0, 32'h0000_0005, 8'hFE});
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL lock_hold c%0d got %h exp %h", k, obs, e); end
    end
    lock = 0;
    sb.push_back('{1'b0, 1'b1, 32'h0000_F000, 8'hF0});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL lock_release got %h exp %h", obs, e); end
    // Lock does not keep an owner that has stopped requesting.
    lock = 1; req_a = 0; req_b = 0; value_b = 32'h0000_0001;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) sb.push_back('{1'b0, 1'b1, 32'h0000_F000, 8'hF0});
      else       sb.push_back(IDLE_EXP);
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL lock_idle c%0d got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    do_reset();
    req_a = 1; value_a = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin req_a = 0; value_a = 32'hDEAD_BEEF; end
      if (k < 4) sb.push_back('{1'b1, 1'b0, 32'h1234_5678, 8'h00});
      else       sb.push_back(IDLE_EXP);
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL freeze c%0d got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    do_reset();
    req_a = 1; value_a = 32'h0;
    sb.push_back('{1'b1, 1'b0, 32'h0, 8'hFE});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL zero_value got %h exp %h", obs, e); end
    value_a = 32'h0000_0009;
    sb.push_back('{1'b1, 1'b0, 32'h0000_0009, 8'hFE});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL zero_one_digit got %h exp %h", obs, e); end
    value_a = 32'h8000_0000;
    sb.push_back('{1'b1, 1'b0, 32'h8000_0000, 8'h00});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL zero_top_digit got %h exp %h", obs, e); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    req_b = 1; value_b = 32'h0000_0ABC;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, 1'b1, 32'h0000_0ABC, 8'hF8});
      @(posedge clock); #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_errs++; $display("FAIL mid_own c%0d got %h exp %h", k, obs, e); end
    end
    #2 resetn = 0;
    sb.push_back(IDLE_EXP);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL mid_reset got %h exp %h", obs, e); end
    #2 resetn = 1;
    sb.push_back('{1'b0, 1'b1, 32'h0000_0ABC, 8'hF8});
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errs++; $display("FAIL mid_regrant got %h exp %h", obs, e); end
  endtask

  initial begin
    resetn = 1; req_a = 0; req_b = 0; lock = 0; value_a = '0; value_b = '0;
    test_reset();
    test_single();
    test_preempt();
    test_lock();
    test_freeze();
    test_zero();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_errs++;
      $display("FAIL scoreboard_left got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
